// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced button levels to PRESS/LONG/REPEAT/RELEASE event queue
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous, active-high
//   db_button_i     debounced button levels, 1 = pressed
//   event_valid_o   FIFO head holds an event
//   event_ready_i   consumer accepts the head when high with event_valid_o
//   event_btn_o     button index of the head event (0 while not valid)
//   event_type_o    00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE (0 while not valid)
//   fifo_count_o    current FIFO occupancy
//   overflow_o      sticky, an event was dropped since reset

module button_event_ctrl #(
  parameter int NUM_BTN    = 4,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int FIFO_DEPTH = 8,
  localparam int BW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] db_button_i,
  output logic               event_valid_o,
  input  logic               event_ready_i,
  output logic [BW-1:0]      event_btn_o,
  output logic [1:0]         event_type_o,
  output logic [CW-1:0]      fifo_count_o,
  output logic               overflow_o
);

  localparam int MAXC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_LONG    = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b11;

  typedef enum logic [1:0] {IDLE, HELD, LONG_ST} state_t;

  logic [NUM_BTN-1:0] db_prev;
  logic [NUM_BTN-1:0] rise, fall;
  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [TW-1:0]      timer_q [NUM_BTN];
  logic [TW-1:0]      timer_d [NUM_BTN];
  logic [NUM_BTN-1:0] ev_raise;
  logic [1:0]         ev_type [NUM_BTN];

  logic [NUM_BTN-1:0] pend_valid;
  logic [1:0]         pend_type [NUM_BTN];
  logic               overflow_q;

  logic [BW-1:0]      last_grant, grant_idx;
  logic               grant_any, grant_en;
  logic [NUM_BTN-1:0] grant_vec;

  logic [BW+1:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               fifo_full, pop;

  assign rise = db_button_i & ~db_prev;
  assign fall = ~db_button_i & db_prev;

  // Per-button press FSM; fall outranks the timer threshold so a release on
  // the threshold cycle yields RELEASE only.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]  = state_q[i];
      timer_d[i]  = timer_q[i];
      ev_raise[i] = 1'b0;
      ev_type[i]  = EV_PRESS;
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i]  = HELD;
            timer_d[i]  = '0;
            ev_raise[i] = 1'b1;
            ev_type[i]  = EV_PRESS;
          end
        end
        HELD: begin
          if (fall[i]) begin
            state_d[i]  = IDLE;
            ev_raise[i] = 1'b1;
            ev_type[i]  = EV_RELEASE;
          end else if (timer_q[i] == LONG_LAST) begin
            state_d[i]  = LONG_ST;
            timer_d[i]  = '0;
            ev_raise[i] = 1'b1;
            ev_type[i]  = EV_LONG;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        LONG_ST: begin
          if (fall[i]) begin
            state_d[i]  = IDLE;
            ev_raise[i] = 1'b1;
            ev_type[i]  = EV_RELEASE;
          end else if (timer_q[i] == REP_LAST) begin
            timer_d[i]  = '0;
            ev_raise[i] = 1'b1;
            ev_type[i]  = EV_REPEAT;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_prev <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      db_prev <= db_button_i;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Round-robin: first scan indices above last_grant, then wrap to the rest.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pend_valid[i] && (i > int'(last_grant)) && !grant_any) begin
        grant_any = 1'b1;
        grant_idx = BW'(i);
      end
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pend_valid[i] && (i <= int'(last_grant)) && !grant_any) begin
        grant_any = 1'b1;
        grant_idx = BW'(i);
      end
    end
  end

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign pop       = (count != '0) & event_ready_i;
  assign grant_en  = grant_any & (~fifo_full | pop);

  always_comb begin
    grant_vec = '0;
    if (grant_en) grant_vec[grant_idx] = 1'b1;
  end

  // A slot being granted this cycle frees up in time to take a new event.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) pend_type[i] <= EV_PRESS;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (ev_raise[i]) begin
          if (!pend_valid[i] || grant_vec[i]) begin
            pend_valid[i] <= 1'b1;
            pend_type[i]  <= ev_type[i];
          end else begin
            overflow_q <= 1'b1;
          end
        end else if (grant_vec[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (grant_en) fifo_mem[wr_ptr] <= {grant_idx, pend_type[grant_idx]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= BW'(NUM_BTN - 1);
    end else begin
      if (grant_en) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_grant <= grant_idx;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({grant_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign event_valid_o = (count != '0);
  assign event_btn_o   = event_valid_o ? fifo_mem[rd_ptr][BW+1:2] : '0;
  assign event_type_o  = event_valid_o ? fifo_mem[rd_ptr][1:0] : 2'b00;
  assign fifo_count_o  = count;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - self-checking bench for button_event_ctrl

module tb_button_event_ctrl;

  localparam int NB    = 4;
  localparam int LONG  = 10;
  localparam int REP   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = 4'b0000;
  logic       rdy = 1'b1;
  logic       event_valid_o;
  logic [1:0] event_btn_o;
  logic [1:0] event_type_o;
  logic [3:0] fifo_count_o;
  logic       overflow_o;

  int checks = 0;
  int failures = 0;

  button_event_ctrl #(
    .NUM_BTN(NB), .LONG_CYC(LONG), .REPEAT_CYC(REP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clk),
    .reset(rst),
    .db_button_i(btn_in),
    .event_valid_o(event_valid_o),
    .event_ready_i(rdy),
    .event_btn_o(event_btn_o),
    .event_type_o(event_type_o),
    .fifo_count_o(fifo_count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: press age in edges, pending slots, and a queue as FIFO.
  bit m_prev [NB];
  int m_age  [NB];
  bit m_pv   [NB];
  int m_pt   [NB];
  int m_q    [$];
  int m_last;
  bit m_ovf;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] b, input bit r, input bit rs);
    int ev [NB];
    bit pop;
    int g;
    if (rs) begin
      for (int i = 0; i < NB; i++) begin
        m_prev[i] = 0; m_age[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
      end
      m_q.delete();
      m_last = NB - 1;
      m_ovf = 0;
      return;
    end
    pop = (m_q.size() > 0) && r;
    g = -1;
    for (int k = 1; k <= NB; k++) begin
      int c;
      c = (m_last + k) % NB;
      if (g < 0 && m_pv[c]) g = c;
    end
    if (g >= 0 && m_q.size() == DEPTH && !pop) g = -1;
    for (int i = 0; i < NB; i++) begin
      ev[i] = -1;
      if (b[i] && !m_prev[i]) begin
        ev[i] = 0;
        m_age[i] = 0;
      end else if (!b[i] && m_prev[i]) begin
        ev[i] = 3;
      end else if (b[i]) begin
        m_age[i]++;
        if (m_age[i] == LONG) ev[i] = 1;
        else if (m_age[i] > LONG && (m_age[i] - LONG) % REP == 0) ev[i] = 2;
      end
      m_prev[i] = b[i];
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g * 4 + m_pt[g]);
      m_pv[g] = 0;
      m_last = g;
    end
    for (int i = 0; i < NB; i++) begin
      if (ev[i] >= 0) begin
        if (!m_pv[i]) begin
          m_pv[i] = 1;
          m_pt[i] = ev[i];
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic model_compare();
    bit v;
    v = (m_q.size() != 0);
    chk("m_valid", int'(event_valid_o), int'(v));
    chk("m_btn", int'(event_btn_o), v ? m_q[0] / 4 : 0);
    chk("m_type", int'(event_type_o), v ? m_q[0] % 4 : 0);
    chk("m_count", int'(fifo_count_o), m_q.size());
    chk("m_ovf", int'(overflow_o), int'(m_ovf));
  endtask

  // Inputs are held across the next rising edge, then outputs are sampled 1 ns later.
  task automatic step(input logic [3:0] b, input bit r, input bit rs);
    btn_in = b;
    rdy = r;
    rst = rs;
    @(posedge clk);
    #1;
    model_step(b, r, rs);
    model_compare();
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    int         v;
    int         b;
    int         t;
    int         c;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic [3:0] btn, input int v, input int b, input int t, input int c);
    vec_t e;
    e.btn = btn; e.rdy = 1'b1; e.v = v; e.b = b; e.t = t; e.c = c;
    tbl.push_back(e);
  endfunction

  initial begin
    int exp_t;
    int hb [9];
    int ht [9];
    int hc [9];
    logic [3:0] rb;
    bit rr, rrs;

    // Same-edge contention, round-robin restart after a grant to 1,
    // and release exactly at the LONG threshold.
    add(4'b0000, 0, 0, 0, 0);
    add(4'b1011, 0, 0, 0, 0);
    add(4'b1011, 1, 0, 0, 1);
    add(4'b1011, 1, 1, 0, 1);
    add(4'b1011, 1, 3, 0, 1);
    add(4'b1011, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0);
    add(4'b0000, 1, 0, 3, 1);
    add(4'b0000, 1, 1, 3, 1);
    add(4'b0000, 1, 3, 3, 1);
    add(4'b0010, 0, 0, 0, 0);
    add(4'b0010, 1, 1, 0, 1);
    add(4'b0000, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 3, 1);
    add(4'b1011, 0, 0, 0, 0);
    add(4'b1011, 1, 3, 0, 1);
    add(4'b1011, 1, 0, 0, 1);
    add(4'b1011, 1, 1, 0, 1);
    add(4'b0000, 0, 0, 0, 0);
    add(4'b0000, 1, 3, 3, 1);
    add(4'b0000, 1, 0, 3, 1);
    add(4'b0000, 1, 1, 3, 1);
    add(4'b0000, 0, 0, 0, 0);
    add(4'b0100, 0, 0, 0, 0);
    add(4'b0100, 1, 2, 0, 1);
    for (int i = 0; i < 8; i++) add(4'b0100, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0);
    add(4'b0000, 1, 2, 3, 1);
    add(4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) step(4'b0000, 1, 1);
    chk("rst_valid", int'(event_valid_o), 0);
    chk("rst_count", int'(fifo_count_o), 0);
    chk("rst_ovf", int'(overflow_o), 0);

    foreach (tbl[i]) begin
      step(tbl[i].btn, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d_valid", i), int'(event_valid_o), tbl[i].v);
      chk($sformatf("tbl%0d_btn", i), int'(event_btn_o), tbl[i].b);
      chk($sformatf("tbl%0d_type", i), int'(event_type_o), tbl[i].t);
      chk($sformatf("tbl%0d_count", i), int'(fifo_count_o), tbl[i].c);
      chk($sformatf("tbl%0d_ovf", i), int'(overflow_o), 0);
    end

    // Long press of button 2: PRESS, LONG, two REPEATs, RELEASE.
    for (int s = 0; s < 25; s++) begin
      step((s < 20) ? 4'b0100 : 4'b0000, 1, 0);
      case (s)
        1:       exp_t = 0;
        11:      exp_t = 1;
        15, 19:  exp_t = 2;
        21:      exp_t = 3;
        default: exp_t = -1;
      endcase
      chk($sformatf("lp%0d_valid", s), int'(event_valid_o), int'(exp_t >= 0));
      if (exp_t >= 0) begin
        chk($sformatf("lp%0d_btn", s), int'(event_btn_o), 2);
        chk($sformatf("lp%0d_type", s), int'(event_type_o), exp_t);
      end
    end

    // Stalled consumer: 8 queued, one pending, 10th event overflows,
    // then drain with push+pop at full.
    for (int s = 0; s < 5; s++) step(4'b1111, 0, 0);
    for (int s = 0; s < 5; s++) step(4'b0000, 0, 0);
    chk("full_count", int'(fifo_count_o), 8);
    step(4'b0001, 0, 0);
    chk("pend_count", int'(fifo_count_o), 8);
    chk("pend_ovf", int'(overflow_o), 0);
    step(4'b0000, 0, 0);
    chk("drop_ovf", int'(overflow_o), 1);
    hb = '{3, 0, 1, 2, 3, 0, 1, 2, 0};
    ht = '{0, 0, 0, 0, 3, 3, 3, 3, 0};
    hc = '{8, 8, 7, 6, 5, 4, 3, 2, 1};
    for (int j = 0; j < 9; j++) begin
      if (j > 0) step(4'b0000, 1, 0);
      chk($sformatf("drain%0d_btn", j), int'(event_btn_o), hb[j]);
      chk($sformatf("drain%0d_type", j), int'(event_type_o), ht[j]);
      chk($sformatf("drain%0d_count", j), int'(fifo_count_o), hc[j]);
    end
    step(4'b0000, 1, 0);
    chk("drain_empty", int'(event_valid_o), 0);
    chk("ovf_sticky", int'(overflow_o), 1);

    // Reset while button 1 is held and 3 events are queued.
    for (int s = 0; s < 4; s++) step(4'b1011, 0, 0);
    chk("pre_rst_count", int'(fifo_count_o), 3);
    step(4'b0010, 0, 1);
    chk("mid_rst_valid", int'(event_valid_o), 0);
    chk("mid_rst_btn", int'(event_btn_o), 0);
    chk("mid_rst_type", int'(event_type_o), 0);
    chk("mid_rst_count", int'(fifo_count_o), 0);
    chk("mid_rst_ovf", int'(overflow_o), 0);
    step(4'b0010, 1, 0);
    chk("post_rst1_valid", int'(event_valid_o), 0);
    step(4'b0010, 1, 0);
    chk("post_rst2_valid", int'(event_valid_o), 1);
    chk("post_rst2_btn", int'(event_btn_o), 1);
    chk("post_rst2_type", int'(event_type_o), 0);
    step(4'b0000, 1, 0);
    for (int s = 0; s < 4; s++) step(4'b0000, 1, 0);

    // Random traffic against the reference model.
    rb = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 19) == 0) rb[i] = ~rb[i];
      if ((n % 300) < 90) rr = ($urandom_range(0, 9) == 0);
      else rr = ($urandom_range(0, 3) != 0);
      rrs = ($urandom_range(0, 999) == 0);
      step(rb, rr, rrs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
